// File: rtl/div_unit_pkg.sv
// div_unit shared defines: state encodings, handshake levels, bus types.
// Optional early-out path is enabled by DIV_EARLY_OUT_EN.
package div_unit_pkg;

  localparam int DataWidth = 32;

  typedef logic [2*DataWidth-1:0] DoubleRegBus;

  localparam logic RstEnable = 1'b1;
  localparam logic [DataWidth-1:0] ZeroWord = '0;

  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree,
    DivByZero,
    DivOn,
    DivEnd
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration of the divider.
// Produces the next partial-remainder/quotient register.
module div_step
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DataWidth
) (
  input  logic [2*WIDTH:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [2*WIDTH:0] next
);

  logic [WIDTH:0] diff;

  assign diff = dividend[2*WIDTH:WIDTH] - {1'b0, divisor};

  assign next = diff[WIDTH]
    ? {dividend[2*WIDTH-1:0], 1'b0}
    : {diff[WIDTH-1:0], dividend[WIDTH-1:0], 1'b1};

endmodule

// File: rtl/div_unit.sv
// Iterative signed/unsigned divider for DIV/DIVU, one bit per clock.
// DIV_EARLY_OUT_EN: finish at acceptance when |dividend| < |divisor|.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = DataWidth
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               start_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LastIter = CW'(WIDTH - 1);

  div_state_e state, state_n;

  logic [CW-1:0]      cnt, cnt_n;
  logic [2*WIDTH:0]   dvd, dvd_n, dvd_step;
  logic [WIDTH-1:0]   mag, mag_n;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH-1:0]   quo, rem;
  logic               neg_q, neg_q_n;
  logic               neg_r, neg_r_n;
  logic [2*WIDTH-1:0] res_n;
  logic               rdy_n;
  logic               abort;

  assign a_mag = (signed_div_i && opdata1_i[WIDTH-1])
    ? -opdata1_i : opdata1_i;
  assign b_mag = (signed_div_i && opdata2_i[WIDTH-1])
    ? -opdata2_i : opdata2_i;

  assign abort = annul_i || (start_i == DivStop);

  div_step #(.WIDTH(WIDTH)) u_step (
    .dividend (dvd),
    .divisor  (mag),
    .next     (dvd_step)
  );

  // Sign fix-up is applied to the value produced by the final iteration
  assign quo = neg_q ? -dvd_step[WIDTH-1:0]
                     :  dvd_step[WIDTH-1:0];
  assign rem = neg_r ? -dvd_step[2*WIDTH:WIDTH+1]
                     :  dvd_step[2*WIDTH:WIDTH+1];

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state    <= DivFree;
      cnt      <= '0;
      dvd      <= '0;
      mag      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      dvd      <= dvd_n;
      mag      <= mag_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      result_o <= res_n;
      ready_o  <= rdy_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvd_n   = dvd;
    mag_n   = mag;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    res_n   = result_o;
    rdy_n   = ready_o;
    unique case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == WIDTH'(ZeroWord)) begin
            state_n = DivByZero;
          end else begin
`ifdef DIV_EARLY_OUT_EN
            if (a_mag < b_mag) begin
              state_n = DivEnd;
              res_n   = {opdata1_i, {WIDTH{1'b0}}};
              rdy_n   = DivResultReady;
            end else begin
`else
            begin
`endif
              state_n = DivOn;
              cnt_n   = '0;
              dvd_n   = {{WIDTH{1'b0}}, a_mag, 1'b0};
              mag_n   = b_mag;
              neg_q_n = signed_div_i &&
                (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r_n = signed_div_i && opdata1_i[WIDTH-1];
            end
          end
        end
      end
      DivByZero: begin
        if (abort) begin
          state_n = DivFree;
          res_n   = '0;
          rdy_n   = DivResultNotReady;
        end else begin
          state_n = DivEnd;
          res_n   = '0;
          rdy_n   = DivResultReady;
        end
      end
      DivOn: begin
        if (abort) begin
          state_n = DivFree;
          cnt_n   = '0;
          res_n   = '0;
          rdy_n   = DivResultNotReady;
        end else begin
          dvd_n = dvd_step;
          cnt_n = cnt + 1'b1;
          if (cnt == LastIter) begin
            state_n = DivEnd;
            res_n   = {rem, quo};
            rdy_n   = DivResultReady;
          end
        end
      end
      DivEnd: begin
        if (abort) begin
          state_n = DivFree;
          cnt_n   = '0;
          res_n   = '0;
          rdy_n   = DivResultNotReady;
        end
      end
      default: begin
        state_n = DivFree;
      end
    endcase
  end

endmodule

// File: tb/tb_div_unit.sv
// Randomized bench for div_unit against a plain-arithmetic reference.
// Honors DIV_EARLY_OUT_EN in its latency expectations.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        signed_div_i = 1'b0;
  logic [31:0] opdata1_i = '0;
  logic [31:0] opdata2_i = '0;
  logic        start_i = 1'b0;
  logic        annul_i = 1'b0;
  logic [63:0] result_o;
  logic        ready_o;

  logic        chk_en  = 1'b0;
  logic        exp_rdy = 1'b0;
  logic [63:0] exp_res = '0;
  string       tag = "reset";
  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (ready_o !== exp_rdy || result_o !== exp_res) begin
        n_fail++;
        $display("FAIL %s cyc=%0d ready got %b want %b result got %h want %h",
                 tag, cyc, ready_o, exp_rdy, result_o, exp_res);
      end
    end
  end

  function automatic logic [63:0] model(input logic [31:0] a,
                                        input logic [31:0] b,
                                        input logic s);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? 32'd0 - v : v;
  endfunction

  function automatic int lat(input logic [31:0] a, input logic [31:0] b,
                             input logic s);
    if (b == 32'd0) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (mag(a, s) < mag(b, s)) return 0;
`endif
    return 32;
  endfunction

  // ab_kind: 0 annul, 1 start drop, 2 reset; exit_kind: 0 start low, 1 annul
  task automatic run_div(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input int ab_at, input int ab_kind,
                         input int exit_kind, input logic use_lit,
                         input logic [63:0] lit, input string name);
    int L;
    logic [63:0] r;
    tag = name;
    L = lat(a, b, s);
    r = use_lit ? lit : model(a, b, s);
    opdata1_i = a;
    opdata2_i = b;
    signed_div_i = s;
    start_i = 1'b1;
    annul_i = 1'b0;
    @(posedge clk); #1;
    opdata1_i = $urandom;
    opdata2_i = $urandom;
    signed_div_i = 1'($urandom);
    if (L == 0) begin
      exp_rdy = 1'b1;
      exp_res = r;
    end
    for (int e = 1; e <= L; e++) begin
      if (e == ab_at) begin
        case (ab_kind)
          0: annul_i = 1'b1;
          1: start_i = 1'b0;
          default: rst = 1'b1;
        endcase
      end
      @(posedge clk); #1;
      if (e == ab_at) begin
        annul_i = 1'b0;
        start_i = 1'b0;
        rst = 1'b0;
        return;
      end
      if (e == L) begin
        exp_rdy = 1'b1;
        exp_res = r;
      end
    end
    if (ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s cyc=%0d timeout: ready_o not set after %0d edges",
               name, cyc, L);
    end
    repeat ($urandom_range(0, 3)) begin
      @(posedge clk); #1;
    end
    if (exit_kind == 0) begin
      start_i = 1'b0;
      @(posedge clk); #1;
    end else begin
      annul_i = 1'b1;
      @(posedge clk); #1;
      annul_i = 1'b0;
      start_i = 1'b0;
    end
    exp_rdy = 1'b0;
    exp_res = '0;
  endtask

  initial begin
    logic [31:0] a, b;
    logic        s;
    int          ab;
    int          L;
    @(posedge clk); #1;
    chk_en = 1'b1;
    if (ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset state: ready %b result %h", ready_o, result_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, -1, 0, 0, 1'b1,
            {32'h2, 32'hE}, "udiv_100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, -1, 0, 0, 1'b1,
            {32'hFFFFFFFF, 32'hFFFFFFFD}, "sdiv_m7_2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, -1, 0, 0, 1'b1,
            {32'h0, 32'h80000000}, "sdiv_ovf");
    run_div(32'h12345678, 32'd0, 1'b0, -1, 0, 0, 1'b1,
            64'd0, "div_by_zero");
    run_div(32'd1000, 32'd3, 1'b0, 10, 0, 0, 1'b0, '0, "annul_e10");
    run_div(32'd100, 32'd7, 1'b0, -1, 0, 0, 1'b1,
            {32'h2, 32'hE}, "after_annul");
    run_div(32'd5, 32'd9, 1'b0, -1, 0, 0, 1'b1,
            {32'h5, 32'h0}, "udiv_5_9");
    run_div(32'hFFFFFFF9, 32'd5, 1'b1, -1, 0, 1, 1'b1,
            {32'hFFFFFFFE, 32'hFFFFFFFF}, "sdiv_m7_5");
    run_div(32'd77, 32'hFFFFFFF6, 1'b1, -1, 0, 1, 1'b1,
            {32'h7, 32'hFFFFFFF9}, "sdiv_77_m10");
    run_div(32'hFFFFFFFF, 32'd16, 1'b0, 20, 1, 0, 1'b0, '0, "start_drop");
    run_div(32'hDEADBEEF, 32'd3, 1'b0, 15, 2, 0, 1'b0, '0, "mid_reset");
    run_div(32'h1, 32'd0, 1'b1, 1, 0, 0, 1'b0, '0, "byzero_annul");
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, -1, 0, 1, 1'b1,
            {32'h0, 32'hFFFFFFFF}, "udiv_max_1");

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = 32'd0 - $urandom_range(1, 20);
        3: a = $urandom_range(0, 50);
        4: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        default: ;
      endcase
      L = lat(a, b, s);
      ab = -1;
      if (L > 0 && $urandom_range(0, 9) == 0) ab = $urandom_range(1, L);
      run_div(a, b, s, ab, $urandom_range(0, 2), $urandom_range(0, 1),
              1'b0, '0, "random");
    end

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
